// File: rtl/mux8_arb_pkg.sv
// mux8_arb_pkg: shared sizes, FSM state type and one-hot helper for the 8-way round-robin mux arbiter.
package mux8_arb_pkg;
  localparam int N_REQ = 8;
  localparam int SEL_W = 3;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction
endpackage

// File: rtl/rr_pick8.sv
// rr_pick8: combinational rotate-priority picker; ptr has top priority, masked requesters are skipped.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic             any,
  output logic [SEL_W-1:0] idx
);
  logic [N_REQ-1:0] eff;
  assign eff = req & ~mask;
  // Scan farthest-first so the nearest eligible requester after ptr wins last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (eff[ptr + SEL_W'(i)]) begin
        any = 1'b1;
        idx = ptr + SEL_W'(i);
      end
  end
endmodule

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin arbiter driving a registered 8x1 mux; MUX8_ARB_HOLD_LIMIT_EN adds a grant tenure limit.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
`ifdef MUX8_ARB_HOLD_LIMIT_EN
#(
  parameter int unsigned HOLD_MAX = 15
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] din,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             y,
  output logic             busy
);
  state_t           state;
  logic [SEL_W-1:0] ptr, pick_ptr, pick_idx;
  logic [N_REQ-1:0] pick_mask;
  logic             pick_any, owner_done;
  // While granted, the search starts after the owner and excludes it, giving a bubble-free handoff.
  assign pick_ptr  = (state == GRANT) ? sel + SEL_W'(1) : ptr;
  assign pick_mask = (state == GRANT) ? onehot8(sel) : '0;
  rr_pick8 u_pick (
    .req  (req),
    .ptr  (pick_ptr),
    .mask (pick_mask),
    .any  (pick_any),
    .idx  (pick_idx)
  );
`ifdef MUX8_ARB_HOLD_LIMIT_EN
  logic [7:0] cnt;
  logic       cnt_max;
  assign cnt_max    = cnt == 8'(HOLD_MAX - 1);
  assign owner_done = !req[sel] || (cnt_max && pick_any);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (state == IDLE || owner_done) cnt <= '0;
    else if (!cnt_max) cnt <= cnt + 8'd1;
`else
  assign owner_done = !req[sel];
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      y     <= 1'b0;
      busy  <= 1'b0;
      ptr   <= '0;
    end else begin
      y <= (state == GRANT) && din[sel];
      if (state == IDLE) begin
        if (pick_any) begin
          state <= GRANT;
          gnt   <= onehot8(pick_idx);
          sel   <= pick_idx;
          busy  <= 1'b1;
        end
      end else if (owner_done) begin
        ptr <= pick_ptr;
        if (pick_any) begin
          gnt <= onehot8(pick_idx);
          sel <= pick_idx;
        end else begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter/sequencer sharing one 8x1 mux datapath among 8 requesters.
- Each requester presents a request bit and a 1-bit data input.
- Block issues a one-hot grant, drives the 3-bit mux select (s2,s1,s0 as sel[2:0]) and outputs a registered y from the granted input.
- Sits between requester logic and the existing 8x1 mux; also usable standalone, because it contains the registered mux function.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 for this block.
- SEL_W, 3, select width; must equal log2(N_REQ).
- HOLD_MAX, 15, maximum grant tenure in cycles; used only with the optional feature; legal range 1..255.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request per requester; bit k = requester k.
- din  input  8  data per requester; din[k] corresponds to mux input ik.
- gnt  output  8  registered one-hot grant, or all zero when idle.
- sel  output  3  registered mux select = index of the granted requester; sel[2]=s2, sel[0]=s0.
- y  output  1  registered mux output.
- busy  output  1  high while in GRANT.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt=0, sel=0, y=0, busy=0, rr pointer ptr=0, tenure counter=0. Reset applies immediately mid-grant; no handoff or flush.
- Pick function: first k with req[k]=1, searching ptr, ptr+1, ..., wrapping 7->0; ptr itself has highest priority.
- IDLE: at an edge where req!=0:
  - gnt<=onehot(pick), sel<=pick, state<=GRANT, busy<=1.
  - Latency: req sampled at edge n -> gnt/sel valid after edge n.
- GRANT, owner o=sel:
  - req[o]=1: hold gnt/sel.
  - req[o]=0 and another req pending: direct handoff in the same edge, with no idle bubble. The owner is ineligible in that pick. ptr<=o+1 mod 8 before the pick, i.e. the pick starts at o+1.
  - req[o]=0 and no other req: gnt<=0, state<=IDLE, busy<=0, ptr<=o+1 mod 8, sel holds its last value.
- y: each edge, y<=din[sel] if state==GRANT, else y<=0.
  - y lags sel by one cycle: din[o] sampled at edge n+1 appears after edge n+1.
  - The first valid y is one cycle after gnt rises.
- ptr updates only on release or handoff. Wrap 7->0 is mandatory.
- gnt is always one-hot or zero; sel always equals the index of the set gnt bit while busy.
- Owner re-requesting in the same cycle it releases is not possible, since a held req is not a release. Release requires at least one cycle with req[o] low.

Optional Feature:
- Macro: MUX8_ARB_HOLD_LIMIT_EN.
- Defined:
  - 8-bit tenure counter clears on each new grant and increments each GRANT cycle.
  - When counter==HOLD_MAX-1 and any other req is pending, force handoff as for a release. ptr<=o+1 and the owner loses the grant even with req[o]=1.
  - If no other req is pending, the owner keeps the grant and the counter saturates.
- Undefined: no counter logic; the grant is held until the owner drops req.

Decomposition:
- Package mux8_arb_pkg holds:
  - N_REQ and SEL_W localparams.
  - State enum {IDLE, GRANT}.
  - Function onehot8(idx).
- Sub-module rr_pick8: combinational rotate-priority picker.
  - Inputs: req[7:0], ptr[2:0], mask[7:0] (owner exclusion).
  - Outputs: any, idx[2:0].
- Top holds the FSM, ptr, counter, and the y register.

Test Plan:
- Reset then req=8'b0000_0100, din=8'hFF -> after next edge gnt=8'h04, sel=3'd2, busy=1; one edge later y=1.
- Owner 2 holds, req=8'b1000_0101, then req[2] drops -> same edge gnt=8'h80, sel=7 (handoff, no bubble); next release with req=8'h01 -> gnt=8'h01 (wrap).
- All req=8'hFF, each owner drops after 2 cycles -> grant order 0,1,...,7,0; gnt always one-hot.
- Single owner 5 releases with req=0 -> gnt=0, busy=0, y=0 after the next edge, sel stays 5; next req=8'hFF -> gnt=8'h40 (ptr=6).
- rst_n pulsed low mid-grant, asynchronously between edges -> gnt, y, busy go to 0 immediately; after release, req=8'h80 with 8'h01 also set -> grant 0 (ptr reset).
- With MUX8_ARB_HOLD_LIMIT_EN and HOLD_MAX=4: owner 1 holds req, req[3]=1 -> gnt moves to 8'h08 after 4 GRANT cycles. Without the macro, gnt stays 8'h02 indefinitely.
